lvds_align_ctrl: RTL
====================

LVDS_ALIGN_CTRL -- requirements
Module: lvds_align_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 4, is the number of 7-bit pixel lanes sequenced; legal range is 1..8.
REQ-002 Parameter CLK_PATTERN, default 7'b110_0011, is the training word each lane must present.
REQ-003 Parameter MATCH_COUNT, default 8, is the number of consecutive matches needed to declare a lane aligned.
REQ-004 Parameter SETTLE_CYCLES, default 6, is the number of wait cycles after a lane select or a slip.
REQ-005 Parameter MAX_SLIPS, default 14, is the slip budget per lane before that lane is declared failed.
REQ-006 px_clk  in  1  pixel clock; every flop in the block is on rising edge.
REQ-007 px_reset  in  1  asynchronous, active-high reset.
REQ-008 rx_ready_i  in  1  level input, already synchronized to px_clk; high means the RX side is running.
REQ-009 restart  in  1  single-cycle pulse that requests full realignment.
REQ-010 lane_data  in  7*NUM_LANES  pixel word per lane; lane k occupies bits [7k+6:7k].
REQ-011 lane_slip  out  NUM_LANES  single-cycle pulse that slips lane k's gearbox by one bit.
REQ-012 lane_aligned  out  NUM_LANES  registered, per-lane aligned flag.
REQ-013 cur_lane  out  3  index of the lane currently being serviced.
REQ-014 align_done  out  1  high once every lane has been visited.
REQ-015 align_error  out  1  sticky; high when any lane exhausted MAX_SLIPS.

Function
REQ-016 The FSM SHALL use the states IDLE, SELECT, SETTLE, CHECK, SLIP, NEXT and DONE; only one lane is serviced at a time.
REQ-017 IDLE: hold until rx_ready_i=1, then clear lane_aligned, align_error and cur_lane, then go to SELECT.
REQ-018 SELECT: clear match_cnt, slip_cnt and settle_cnt, then go to SETTLE the next cycle.
REQ-019 SETTLE: count SETTLE_CYCLES cycles, then go to CHECK; no comparison is made while in SETTLE.
REQ-020 CHECK: each cycle, compare lane_data[cur_lane] with CLK_PATTERN.
REQ-021 CHECK on a match: increment match_cnt; if this is match number MATCH_COUNT, set lane_aligned[cur_lane] and go to NEXT.
REQ-022 CHECK on a mismatch: clear match_cnt; go to SLIP if slip_cnt<MAX_SLIPS, otherwise set align_error and go to NEXT with lane_aligned[cur_lane]=0.
REQ-023 SLIP: assert lane_slip[cur_lane] for exactly one cycle, increment slip_cnt, clear settle_cnt, then go to SETTLE.
REQ-024 NEXT: if cur_lane==NUM_LANES-1 go to DONE; otherwise increment cur_lane and go to SELECT.
REQ-025 DONE: assert align_done and hold lane_aligned; no slips are issued in DONE.
REQ-026 Latency from rx_ready_i rising to the first CHECK cycle SHALL be exactly 2+SETTLE_CYCLES cycles.
REQ-027 rx_ready_i=0 in any non-IDLE state SHALL force IDLE on the next edge and clear align_done and lane_aligned; align_error is kept until the next IDLE exit.
REQ-028 restart SHALL behave like rx_ready_i=0 for one cycle; if restart and a match arrive in the same cycle, restart wins.
REQ-029 At most one lane_slip bit SHALL be high in any cycle; no bit of lane_slip is ever high outside SLIP.
REQ-030 Counters SHALL saturate and never wrap; match_cnt and slip_cnt are sized clog2(param+1).

Reset
REQ-031 While px_reset=1 the block SHALL be in state IDLE with lane_slip=0, lane_aligned=0, cur_lane=0, align_done=0, align_error=0 and all counters at 0.
REQ-032 After reset is released, the block SHALL leave IDLE no earlier than the first px_clk edge that samples rx_ready_i=1.

Structure
REQ-033 The state encoding enum and the default CLK_PATTERN SHALL live in the shared package lvds_pkg.
REQ-034 The design SHALL have one sub-module, lvds_lane_mux, which selects lane_data[cur_lane] combinationally; the FSM stays in the top module.

Verification
REQ-035 Reset test: all four lanes present the pattern, rx_ready_i rises -> no slips; lane_aligned goes 0001, 0011, 0111, 1111 in sequence; align_done=1; align_error=0.
REQ-036 Slip test: lane 2 is 3 bits off -> exactly three lane_slip[2] pulses, each separated by 7 or more cycles; lane_aligned=1111.
REQ-037 Failure test: lane 1 carries 7'h00 -> 15 CHECK mismatches, 14 slips, align_error=1; final lane_aligned=1101 and align_done=1.
REQ-038 Drop test: rx_ready_i falls during lane 2 SETTLE -> IDLE on the next edge and lane_aligned=0000; when rx_ready_i rises again, alignment restarts at lane 0.
REQ-039 Collision test: restart in the same cycle as the 8th match on lane 0 -> lane_aligned[0] stays 0 and the FSM goes to IDLE.
REQ-040 Async reset test: assert px_reset mid-SLIP, between clock edges -> lane_slip drops immediately and all outputs take their reset values.

Source files
------------

// File: rtl/lvds_pkg.sv
// ---------------------------------------------------------------------------
// lvds_pkg
// Shared definitions for the LVDS lane alignment controller:
//   - align_state_e       : alignment FSM state encoding (also the debug view)
//   - CLK_PATTERN_DEFAULT : training word every lane presents when aligned
//   - PIXEL_BITS          : width of one pixel lane word
// ---------------------------------------------------------------------------
package lvds_pkg;

    localparam int PIXEL_BITS = 7;

    localparam logic [PIXEL_BITS-1:0] CLK_PATTERN_DEFAULT = 7'b110_0011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_SLIP   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } align_state_e;

endpackage

// File: rtl/lvds_lane_mux.sv
// ---------------------------------------------------------------------------
// lvds_lane_mux
// Combinational selector returning the pixel word of the lane being serviced.
// Ports:
//   lane_data  in  7*NUM_LANES  packed lane words, lane k at [7k+6:7k]
//   sel        in  3            lane index
//   word       out 7            lane_data word of lane 'sel' (0 if out of range)
// ---------------------------------------------------------------------------
module lvds_lane_mux
    import lvds_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [PIXEL_BITS*NUM_LANES-1:0] lane_data,
    input  logic [2:0]                      sel,
    output logic [PIXEL_BITS-1:0]           word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel == 3'(i)) begin
                word = lane_data[PIXEL_BITS*i +: PIXEL_BITS];
            end
        end
    end

endmodule

// File: rtl/lvds_align_ctrl.sv
// ---------------------------------------------------------------------------
// lvds_align_ctrl
// Sequential word-alignment controller for NUM_LANES LVDS pixel lanes. Each
// lane is visited in turn: wait for the gearbox to settle, compare against
// the training word, slip the gearbox by one bit on a mismatch, and declare
// the lane aligned after MATCH_COUNT consecutive matches. A lane that still
// mismatches after MAX_SLIPS slips is marked failed (align_error).
//
// Handshake/level semantics: rx_ready_i is a level; dropping it (or a one
// cycle restart pulse) aborts any in-progress alignment on the next edge and
// returns to IDLE. lane_slip is a single-cycle pulse per requested bit slip.
//
// Ports:
//   px_clk        in   pixel clock (rising edge)
//   px_reset      in   asynchronous, active-high reset
//   rx_ready_i    in   RX running (already synchronous to px_clk)
//   restart       in   one-cycle realign request
//   lane_data     in   7*NUM_LANES pixel words
//   lane_slip     out  one-hot slip pulse for the serviced lane
//   lane_aligned  out  per-lane aligned flags
//   cur_lane      out  lane currently serviced
//   align_done    out  all lanes visited
//   align_error   out  sticky: some lane ran out of slips
//   state_dbg     out  FSM state (align_state_e encoding)
// ---------------------------------------------------------------------------
module lvds_align_ctrl
    import lvds_pkg::*;
#(
    parameter int                    NUM_LANES     = 4,
    parameter logic [PIXEL_BITS-1:0] CLK_PATTERN   = CLK_PATTERN_DEFAULT,
    parameter int                    MATCH_COUNT   = 8,
    parameter int                    SETTLE_CYCLES = 6,
    parameter int                    MAX_SLIPS     = 14
) (
    input  logic                            px_clk,
    input  logic                            px_reset,
    input  logic                            rx_ready_i,
    input  logic                            restart,
    input  logic [PIXEL_BITS*NUM_LANES-1:0] lane_data,
    output logic [NUM_LANES-1:0]            lane_slip,
    output logic [NUM_LANES-1:0]            lane_aligned,
    output logic [2:0]                      cur_lane,
    output logic                            align_done,
    output logic                            align_error,
    output logic [2:0]                      state_dbg
);

    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = $clog2(MAX_SLIPS + 1);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
    localparam logic [MW-1:0] MATCH_MAX   = MW'(MATCH_COUNT);
    localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIPS);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    LAST_LANE   = 3'(NUM_LANES - 1);

    align_state_e          state_q, state_d;
    logic [2:0]            cur_lane_q, cur_lane_d;
    logic [MW-1:0]         match_cnt_q, match_cnt_d;
    logic [SW-1:0]         slip_cnt_q, slip_cnt_d;
    logic [TW-1:0]         settle_cnt_q, settle_cnt_d;
    logic [NUM_LANES-1:0]  lane_aligned_q, lane_aligned_d;
    logic [NUM_LANES-1:0]  lane_slip_q, lane_slip_d;
    logic                  align_done_q, align_done_d;
    logic                  align_error_q, align_error_d;

    logic [PIXEL_BITS-1:0] cur_word;
    logic                  abort;

    lvds_lane_mux #(
        .NUM_LANES (NUM_LANES)
    ) u_lane_mux (
        .lane_data (lane_data),
        .sel       (cur_lane_q),
        .word      (cur_word)
    );

    // Restart is treated exactly like a one-cycle loss of rx_ready.
    assign abort = !rx_ready_i || restart;

    always_comb begin
        state_d        = state_q;
        cur_lane_d     = cur_lane_q;
        match_cnt_d    = match_cnt_q;
        slip_cnt_d     = slip_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        lane_aligned_d = lane_aligned_q;
        align_error_d  = align_error_q;
        lane_slip_d    = '0;
        align_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!abort) begin
                    lane_aligned_d = '0;
                    align_error_d  = 1'b0;
                    cur_lane_d     = '0;
                    state_d        = ST_SELECT;
                end
            end
            ST_SELECT: begin
                match_cnt_d  = '0;
                slip_cnt_d   = '0;
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q >= SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + TW'(1);
                end
            end
            ST_CHECK: begin
                if (cur_word == CLK_PATTERN) begin
                    if (match_cnt_q < MATCH_MAX) begin
                        match_cnt_d = match_cnt_q + MW'(1);
                    end
                    // match_cnt_q still holds the previous count, so this is
                    // the MATCH_COUNT-th consecutive match.
                    if (match_cnt_q >= MATCH_LAST) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (cur_lane_q == 3'(i)) begin
                                lane_aligned_d[i] = 1'b1;
                            end
                        end
                        state_d = ST_NEXT;
                    end
                end else begin
                    match_cnt_d = '0;
                    if (slip_cnt_q < SLIP_MAX) begin
                        state_d = ST_SLIP;
                    end else begin
                        align_error_d = 1'b1;
                        state_d       = ST_NEXT;
                    end
                end
            end
            ST_SLIP: begin
                if (slip_cnt_q < SLIP_MAX) begin
                    slip_cnt_d = slip_cnt_q + SW'(1);
                end
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_NEXT: begin
                if (cur_lane_q == LAST_LANE) begin
                    state_d = ST_DONE;
                end else begin
                    cur_lane_d = cur_lane_q + 3'd1;
                    state_d    = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything decided above, including an aligned
        // flag or error that would have been set this same cycle.
        if (state_q != ST_IDLE && abort) begin
            state_d        = ST_IDLE;
            lane_aligned_d = '0;
            align_error_d  = align_error_q;
        end

        // Outputs are registered against the next state so that lane_slip
        // and align_done are flop outputs coincident with SLIP/DONE.
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_slip_d[i] = (state_d == ST_SLIP) && (cur_lane_d == 3'(i));
        end
        align_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge px_clk or posedge px_reset) begin
        if (px_reset) begin
            state_q        <= ST_IDLE;
            cur_lane_q     <= '0;
            match_cnt_q    <= '0;
            slip_cnt_q     <= '0;
            settle_cnt_q   <= '0;
            lane_aligned_q <= '0;
            lane_slip_q    <= '0;
            align_done_q   <= 1'b0;
            align_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_lane_q     <= cur_lane_d;
            match_cnt_q    <= match_cnt_d;
            slip_cnt_q     <= slip_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            lane_aligned_q <= lane_aligned_d;
            lane_slip_q    <= lane_slip_d;
            align_done_q   <= align_done_d;
            align_error_q  <= align_error_d;
        end
    end

    assign lane_slip    = lane_slip_q;
    assign lane_aligned = lane_aligned_q;
    assign cur_lane     = cur_lane_q;
    assign align_done   = align_done_q;
    assign align_error  = align_error_q;
    assign state_dbg    = state_q;

endmodule
